// File: rtl/ds_link_char_rx_if.sv
// DS-link receive bundle: D/S line pair from the pins and the decoded character/error outputs.
interface ds_link_char_rx_if;
  logic       D_in;
  logic       S_in;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_eop1;
  logic       rx_eop2;
  logic       rx_fcc;
  logic       rx_null;
  logic       rx_got_null;
  logic       err_parity;
  logic       err_escape;
  logic       err_ds;
  logic       err_disconnect;
  logic       rx_error;

  modport master (
    output D_in, S_in,
    input  rx_data, rx_data_valid, rx_eop1, rx_eop2, rx_fcc, rx_null, rx_got_null,
    input  err_parity, err_escape, err_ds, err_disconnect, rx_error
  );

  modport slave (
    input  D_in, S_in,
    output rx_data, rx_data_valid, rx_eop1, rx_eop2, rx_fcc, rx_null, rx_got_null,
    output err_parity, err_escape, err_ds, err_disconnect, rx_error
  );
endinterface

// File: rtl/ds_link_char_rx.sv
// IEEE1355 DS-link character receiver: recovers bits from D/S, locks on the first NULL,
// decodes data/control characters, checks link parity and flags link errors.
module ds_link_char_rx #(
  parameter bit          G_LINK_PARITY_IS_ODD = 1'b1,
  parameter int unsigned G_DISC_CYCLES        = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  ds_link_char_rx_if.slave   link
);

  localparam int unsigned DISC_W = $clog2(G_DISC_CYCLES + 1);

  // Control codes as {b0, b1}, b0 first on the wire.
  localparam logic [1:0] CODE_FCC  = 2'b00;
  localparam logic [1:0] CODE_EOP1 = 2'b01;
  localparam logic [1:0] CODE_EOP2 = 2'b10;

  typedef enum logic [2:0] {
    S_HUNT, S_PAR, S_FLAG, S_CTRL, S_DATA, S_ERROR
  } state_e;

  state_e              state_q;
  logic [2:0]          d_sync_q;
  logic [2:0]          s_sync_q;
  logic [5:0]          sh_q;
  logic [6:0]          data_q;
  logic [2:0]          cnt_q;
  logic                acc_q;
  logic                par_q;
  logic                esc_q;
  logic [DISC_W-1:0]   disc_q;

  logic [7:0]          rx_data_q;
  logic                rx_data_valid_q;
  logic                rx_eop1_q;
  logic                rx_eop2_q;
  logic                rx_fcc_q;
  logic                rx_null_q;
  logic                rx_got_null_q;
  logic                err_parity_q;
  logic                err_escape_q;
  logic                err_ds_q;
  logic                err_disconnect_q;
  logic                rx_error_q;

  logic                d_ev_c;
  logic                s_ev_c;
  logic                bit_ev_c;
  logic                both_ev_c;
  logic                rx_bit_c;
  logic                null_match_c;
  logic                par_ok_c;
  logic [1:0]          code_c;
  logic [7:0]          byte_c;
  logic                disc_hit_c;

  // Bits [1:0] synchronise the pins, bit [2] is the delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sync_q <= 3'b000;
      s_sync_q <= 3'b000;
    end else begin
      d_sync_q <= {d_sync_q[1:0], link.D_in};
      s_sync_q <= {s_sync_q[1:0], link.S_in};
    end
  end

  always_comb begin
    d_ev_c       = d_sync_q[1] ^ d_sync_q[2];
    s_ev_c       = s_sync_q[1] ^ s_sync_q[2];
    bit_ev_c     = d_ev_c | s_ev_c;
    both_ev_c    = d_ev_c & s_ev_c;
    rx_bit_c     = d_sync_q[1];
    // sh_q holds the six bits before the current one; parity positions are don't-care.
    null_match_c = (sh_q[5:3] == 3'b111) && (sh_q[1:0] == 2'b10) && !rx_bit_c;
    par_ok_c     = (acc_q ^ par_q ^ rx_bit_c) == G_LINK_PARITY_IS_ODD;
    code_c       = {data_q[6], rx_bit_c};
    byte_c       = {rx_bit_c, data_q};
    disc_hit_c   = rx_got_null_q && (state_q != S_ERROR) && !bit_ev_c &&
                   (disc_q == DISC_W'(G_DISC_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_HUNT;
      sh_q             <= '0;
      data_q           <= '0;
      cnt_q            <= '0;
      acc_q            <= 1'b0;
      par_q            <= 1'b0;
      esc_q            <= 1'b0;
      disc_q           <= '0;
      rx_data_q        <= 8'h00;
      rx_data_valid_q  <= 1'b0;
      rx_eop1_q        <= 1'b0;
      rx_eop2_q        <= 1'b0;
      rx_fcc_q         <= 1'b0;
      rx_null_q        <= 1'b0;
      rx_got_null_q    <= 1'b0;
      err_parity_q     <= 1'b0;
      err_escape_q     <= 1'b0;
      err_ds_q         <= 1'b0;
      err_disconnect_q <= 1'b0;
      rx_error_q       <= 1'b0;
    end else begin
      rx_data_valid_q  <= 1'b0;
      rx_eop1_q        <= 1'b0;
      rx_eop2_q        <= 1'b0;
      rx_fcc_q         <= 1'b0;
      rx_null_q        <= 1'b0;
      err_parity_q     <= 1'b0;
      err_escape_q     <= 1'b0;
      err_ds_q         <= 1'b0;
      err_disconnect_q <= 1'b0;

      if (!enable) begin
        state_q       <= S_HUNT;
        sh_q          <= '0;
        data_q        <= '0;
        cnt_q         <= '0;
        acc_q         <= 1'b0;
        par_q         <= 1'b0;
        esc_q         <= 1'b0;
        disc_q        <= '0;
        rx_got_null_q <= 1'b0;
        rx_error_q    <= 1'b0;
      end else begin
        // Link-silence counter, saturating at the disconnect threshold.
        if (bit_ev_c) begin
          disc_q <= '0;
        end else if (rx_got_null_q && (disc_q != DISC_W'(G_DISC_CYCLES))) begin
          disc_q <= disc_q + DISC_W'(1);
        end

        if (state_q != S_ERROR) begin
          if (both_ev_c) begin
            err_ds_q   <= 1'b1;
            rx_error_q <= 1'b1;
            state_q    <= S_ERROR;
          end else if (disc_hit_c) begin
            err_disconnect_q <= 1'b1;
            rx_error_q       <= 1'b1;
            state_q          <= S_ERROR;
          end else if (bit_ev_c) begin
            case (state_q)
              S_HUNT: begin
                sh_q <= {sh_q[4:0], rx_bit_c};
                if (null_match_c) begin
                  rx_got_null_q <= 1'b1;
                  rx_null_q     <= 1'b1;
                  acc_q         <= 1'b0;
                  esc_q         <= 1'b0;
                  state_q       <= S_PAR;
                end
              end
              S_PAR: begin
                par_q   <= rx_bit_c;
                state_q <= S_FLAG;
              end
              S_FLAG: begin
                if (!par_ok_c) begin
                  err_parity_q <= 1'b1;
                  rx_error_q   <= 1'b1;
                  state_q      <= S_ERROR;
                end else begin
                  acc_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= rx_bit_c ? S_CTRL : S_DATA;
                end
              end
              S_CTRL: begin
                acc_q  <= acc_q ^ rx_bit_c;
                data_q <= {rx_bit_c, data_q[6:1]};
                cnt_q  <= cnt_q + 3'd1;
                if (cnt_q == 3'd1) begin
                  state_q <= S_PAR;
                  if (esc_q) begin
                    esc_q <= 1'b0;
                    if (code_c == CODE_FCC) begin
                      rx_null_q <= 1'b1;
                    end else begin
                      err_escape_q <= 1'b1;
                      rx_error_q   <= 1'b1;
                      state_q      <= S_ERROR;
                    end
                  end else begin
                    case (code_c)
                      CODE_FCC:  rx_fcc_q  <= 1'b1;
                      CODE_EOP1: rx_eop1_q <= 1'b1;
                      CODE_EOP2: rx_eop2_q <= 1'b1;
                      default:   esc_q     <= 1'b1;
                    endcase
                  end
                end
              end
              S_DATA: begin
                acc_q  <= acc_q ^ rx_bit_c;
                data_q <= {rx_bit_c, data_q[6:1]};
                cnt_q  <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                  state_q <= S_PAR;
                  if (esc_q) begin
                    esc_q        <= 1'b0;
                    err_escape_q <= 1'b1;
                    rx_error_q   <= 1'b1;
                    state_q      <= S_ERROR;
                  end else begin
                    rx_data_q       <= byte_c;
                    rx_data_valid_q <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign link.rx_data        = rx_data_q;
  assign link.rx_data_valid  = rx_data_valid_q;
  assign link.rx_eop1        = rx_eop1_q;
  assign link.rx_eop2        = rx_eop2_q;
  assign link.rx_fcc         = rx_fcc_q;
  assign link.rx_null        = rx_null_q;
  assign link.rx_got_null    = rx_got_null_q;
  assign link.err_parity     = err_parity_q;
  assign link.err_escape     = err_escape_q;
  assign link.err_ds         = err_ds_q;
  assign link.err_disconnect = err_disconnect_q;
  assign link.rx_error       = rx_error_q;

endmodule
